// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        INIT = ST_INIT,
        RUN  = ST_RUN
    } rf_state_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   g,
    output logic            any_valid
);

    int idx;

    always_comb begin
        grant     = '0;
        g         = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap keeps non-power-of-2 NREQ inside the requester range.
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                g          = PW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the regfile write port: clears x1..x31 after reset, then round-robins writeback requesters.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [RF_ADDR_W*NREQ-1:0] req_wa,
    input  logic [RF_DATA_W*NREQ-1:0] req_wd,
    output logic [NREQ-1:0]           req_ready,
    output logic                      werf,
    output logic [RF_ADDR_W-1:0]      wa,
    output logic [RF_DATA_W-1:0]      wd,
    output logic                      init_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rf_state_e              state;
    logic [RF_ADDR_W-1:0]   cnt;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          g;
    logic [PW-1:0]          ptr_next;
    logic [NREQ-1:0]        grant;
    logic                   any_valid;
    logic [RF_ADDR_W-1:0]   sel_wa;
    logic [RF_DATA_W-1:0]   sel_wd;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .g         (g),
        .any_valid (any_valid)
    );

    // Handshake: a requester transfers on any edge where req_valid[i] & req_ready[i];
    // it holds valid/wa/wd until then, and ready never rises without its own valid.
    assign req_ready = (!rst && state == RUN) ? grant : '0;

    assign sel_wa   = req_wa[int'(g)*RF_ADDR_W +: RF_ADDR_W];
    assign sel_wd   = req_wd[int'(g)*RF_DATA_W +: RF_DATA_W];
    assign ptr_next = (int'(g) == NREQ - 1) ? '0 : g + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            werf <= 1'b0;
            wa   <= '0;
            wd   <= '0;
            ptr  <= '0;
            cnt  <= 5'd1;
            if (CLEAR_ON_RESET) begin
                state     <= INIT;
                init_done <= 1'b0;
            end else begin
                state     <= RUN;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= (state == RUN);
            if (state == INIT) begin
                werf <= 1'b1;
                wa   <= cnt;
                wd   <= '0;
                // cnt saturates at 31; the same edge hands the port over to requesters.
                if (cnt == 5'd31) begin
                    state <= RUN;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end else if (any_valid) begin
                // x0 targets are consumed but never reach the regfile.
                werf <= (sel_wa != RF_ZERO_REG);
                wa   <= sel_wa;
                wd   <= sel_wd;
                ptr  <= ptr_next;
            end else begin
                werf <= 1'b0;
            end
        end
    end

endmodule
